// File: rtl/regfile_port_arbiter.sv
// Arbitrates one single-port register file between write-back and two operand reads.
// Optional X0_HARDWIRE_EN: register 0 reads return zero and writes to it are dropped, bypassing the regfile.
module regfile_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_req_i,
    input  logic [REG_AW-1:0] wb_reg_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              wb_gnt_o,
    input  logic              rd0_req_i,
    input  logic [REG_AW-1:0] rd0_reg_i,
    output logic              rd0_gnt_o,
    output logic              rd0_valid_o,
    output logic [XLEN-1:0]   rd0_data_o,
    input  logic              rd1_req_i,
    input  logic [REG_AW-1:0] rd1_reg_i,
    output logic              rd1_gnt_o,
    output logic              rd1_valid_o,
    output logic [XLEN-1:0]   rd1_data_o,
    output logic              rf_write_en_o,
    output logic              rf_read_en_o,
    output logic [REG_AW-1:0] rf_write_reg_o,
    output logic [REG_AW-1:0] rf_read_reg_o,
    output logic [XLEN-1:0]   rf_write_data_o,
    input  logic [XLEN-1:0]   rf_read_data_i
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

    typedef enum logic [1:0] {TAG_NONE, TAG_RD0, TAG_RD1} tag_e;

    tag_e          tag_q, tag_d;
    logic          rr_q, rr_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          z0_q, z1_q;

    logic wb_zero, rd0_zero, rd1_zero;
    logic wb_arb, rd0_arb, rd1_arb, any_rd, read_wins;
    logic wb_sel, rd0_sel, rd1_sel;

`ifdef X0_HARDWIRE_EN
    assign wb_zero  = wb_req_i  && (wb_reg_i  == '0);
    assign rd0_zero = rd0_req_i && (rd0_reg_i == '0);
    assign rd1_zero = rd1_req_i && (rd1_reg_i == '0);
`else
    assign wb_zero  = 1'b0;
    assign rd0_zero = 1'b0;
    assign rd1_zero = 1'b0;
`endif

    // Zero-register accesses never reach the regfile, so they stay out of arbitration.
    assign wb_arb    = wb_req_i  & ~wb_zero;
    assign rd0_arb   = rd0_req_i & ~rd0_zero;
    assign rd1_arb   = rd1_req_i & ~rd1_zero;
    assign any_rd    = rd0_arb | rd1_arb;
    assign read_wins = any_rd && (starve_q == STARVE_TOP);

    always_comb begin
        wb_sel  = 1'b0;
        rd0_sel = 1'b0;
        rd1_sel = 1'b0;
        if (!rst_i) begin
            if (wb_arb && !read_wins) begin
                wb_sel = 1'b1;
            end else if (rd0_arb && rd1_arb) begin
                if (rr_q) rd1_sel = 1'b1;
                else      rd0_sel = 1'b1;
            end else if (rd0_arb) begin
                rd0_sel = 1'b1;
            end else if (rd1_arb) begin
                rd1_sel = 1'b1;
            end
        end
    end

    always_comb begin
        tag_d    = TAG_NONE;
        rr_d     = rr_q;
        starve_d = starve_q;
        if (rd0_sel) begin
            tag_d = TAG_RD0;
            rr_d  = 1'b1;
        end else if (rd1_sel) begin
            tag_d = TAG_RD1;
            rr_d  = 1'b0;
        end
        if (!any_rd || rd0_sel || rd1_sel) begin
            starve_d = '0;
        end else if (wb_sel && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_q    <= TAG_NONE;
            rr_q     <= 1'b0;
            starve_q <= '0;
            z0_q     <= 1'b0;
            z1_q     <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            z0_q     <= rd0_zero;
            z1_q     <= rd1_zero;
        end
    end

    assign wb_gnt_o  = wb_sel  | (wb_zero  & ~rst_i);
    assign rd0_gnt_o = rd0_sel | (rd0_zero & ~rst_i);
    assign rd1_gnt_o = rd1_sel | (rd1_zero & ~rst_i);

    assign rf_write_en_o   = wb_sel;
    assign rf_write_reg_o  = wb_sel ? wb_reg_i  : '0;
    assign rf_write_data_o = wb_sel ? wb_data_i : '0;
    assign rf_read_en_o    = rd0_sel | rd1_sel;
    assign rf_read_reg_o   = rd0_sel ? rd0_reg_i : (rd1_sel ? rd1_reg_i : '0);

    assign rd0_valid_o = (tag_q == TAG_RD0) | z0_q;
    assign rd1_valid_o = (tag_q == TAG_RD1) | z1_q;
    assign rd0_data_o  = (tag_q == TAG_RD0) ? rf_read_data_i : '0;
    assign rd1_data_o  = (tag_q == TAG_RD1) ? rf_read_data_i : '0;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed, table-driven bench for regfile_port_arbiter with a behavioural single-port regfile.
module tb_regfile_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_req, rd0_req, rd1_req;
    logic [4:0]  wb_reg, rd0_reg, rd1_reg;
    logic [31:0] wb_data;
    logic        wb_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
    logic [31:0] rd0_data, rd1_data;
    logic        rf_we, rf_re;
    logic [4:0]  rf_wreg, rf_rreg;
    logic [31:0] rf_wdata, rf_rdata;
    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .wb_req_i(wb_req), .wb_reg_i(wb_reg), .wb_data_i(wb_data), .wb_gnt_o(wb_gnt),
        .rd0_req_i(rd0_req), .rd0_reg_i(rd0_reg), .rd0_gnt_o(rd0_gnt),
        .rd0_valid_o(rd0_valid), .rd0_data_o(rd0_data),
        .rd1_req_i(rd1_req), .rd1_reg_i(rd1_reg), .rd1_gnt_o(rd1_gnt),
        .rd1_valid_o(rd1_valid), .rd1_data_o(rd1_data),
        .rf_write_en_o(rf_we), .rf_read_en_o(rf_re),
        .rf_write_reg_o(rf_wreg), .rf_read_reg_o(rf_rreg),
        .rf_write_data_o(rf_wdata), .rf_read_data_i(rf_rdata)
    );

    // Regfile model: read data registered, held while read_en is low.
    initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_rdata <= 32'h0;
        end else begin
            if (rf_we) mem[rf_wreg] <= rf_wdata;
            if (rf_re) rf_rdata <= mem[rf_rreg];
        end
    end

    typedef struct {
        logic        wb;
        logic [4:0]  wreg;
        logic [31:0] wdat;
        logic        r0;
        logic [4:0]  r0reg;
        logic        r1;
        logic [4:0]  r1reg;
        logic [2:0]  gnt;   // {wb, rd0, rd1}
        logic [1:0]  vld;   // {rd0, rd1}
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wr, input logic [31:0] wd,
                         input logic a, input logic [4:0] ar,
                         input logic b, input logic [4:0] br);
        wb_req = w; wb_reg = wr; wb_data = wd;
        rd0_req = a; rd0_reg = ar;
        rd1_req = b; rd1_reg = br;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {25'h0, wb_gnt, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, rf_we, rf_re}, 32'h0);
        chk({name, "_data"}, rd0_data | rd1_data | rf_wdata, 32'h0);
        chk({name, "_reg"}, {27'h0, rf_wreg | rf_rreg}, 32'h0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
    endtask

    logic rd0_done;

    initial begin
        //          wb wreg wdata         r0 r0reg r1 r1reg  gnt     vld    d0            d1
        vec[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,    0, 0,    3'b100, 2'b00, 32'h0,        32'h0};
        vec[1]  = '{0, 0,  32'h0,        1, 5,    0, 0,    3'b010, 2'b00, 32'h0,        32'h0};
        vec[2]  = '{1, 3,  32'h7,        0, 0,    0, 0,    3'b100, 2'b10, 32'hDEADBEEF, 32'h0};
        vec[3]  = '{0, 0,  32'h0,        0, 0,    1, 3,    3'b001, 2'b00, 32'h0,        32'h0};
        vec[4]  = '{1, 1,  32'h11111111, 0, 0,    0, 0,    3'b100, 2'b01, 32'h0,        32'h7};
        vec[5]  = '{1, 2,  32'h22222222, 0, 0,    0, 0,    3'b100, 2'b00, 32'h0,        32'h0};
        vec[6]  = '{0, 0,  32'h0,        1, 1,    1, 2,    3'b010, 2'b00, 32'h0,        32'h0};
        vec[7]  = '{0, 0,  32'h0,        1, 1,    1, 2,    3'b001, 2'b10, 32'h11111111, 32'h0};
        vec[8]  = '{0, 0,  32'h0,        1, 1,    1, 2,    3'b010, 2'b01, 32'h0,        32'h22222222};
        vec[9]  = '{0, 0,  32'h0,        0, 0,    0, 0,    3'b000, 2'b10, 32'h11111111, 32'h0};
        vec[10] = '{1, 7,  32'h000000AA, 1, 7,    0, 0,    3'b100, 2'b00, 32'h0,        32'h0};
        vec[11] = '{0, 0,  32'h0,        1, 7,    0, 0,    3'b010, 2'b00, 32'h0,        32'h0};
        vec[12] = '{0, 0,  32'h0,        0, 0,    0, 0,    3'b000, 2'b10, 32'h000000AA, 32'h0};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vec[i].wb, vec[i].wreg, vec[i].wdat, vec[i].r0, vec[i].r0reg, vec[i].r1, vec[i].r1reg);
            #1;
            chk($sformatf("v%0d_gnt", i), {29'h0, wb_gnt, rd0_gnt, rd1_gnt}, {29'h0, vec[i].gnt});
            chk($sformatf("v%0d_rfen", i), {30'h0, rf_we, rf_re},
                {30'h0, vec[i].gnt[2], vec[i].gnt[1] | vec[i].gnt[0]});
            chk($sformatf("v%0d_vld", i), {30'h0, rd0_valid, rd1_valid}, {30'h0, vec[i].vld});
            chk($sformatf("v%0d_d0", i), rd0_data, vec[i].d0);
            chk($sformatf("v%0d_d1", i), rd1_data, vec[i].d1);
        end

        // Starvation: wb held 10 cycles against a waiting rd0.
        do_reset();
        rd0_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1, 9, 32'(c), !rd0_done, 4, 0, 0);
            #1;
            chk($sformatf("starve_c%0d_gnt", c), {29'h0, wb_gnt, rd0_gnt, rd1_gnt},
                (c == 4) ? 32'h2 : 32'h4);
            if (c == 5) chk("starve_valid", {31'h0, rd0_valid}, 32'h1);
            if (c == 4) rd0_done = 1'b1;
        end

        // Register 0 write then read.
        @(negedge clk);
        drive(1, 0, 32'h1234, 0, 0, 0, 0);
        #1;
        chk("x0_wb_gnt", {31'h0, wb_gnt}, 32'h1);
`ifdef X0_HARDWIRE_EN
        chk("x0_rf_we", {31'h0, rf_we}, 32'h0);
`else
        chk("x0_rf_we", {31'h0, rf_we}, 32'h1);
`endif
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("x0_rd0_gnt", {31'h0, rd0_gnt}, 32'h1);
`ifdef X0_HARDWIRE_EN
        chk("x0_rf_re", {31'h0, rf_re}, 32'h0);
`else
        chk("x0_rf_re", {31'h0, rf_re}, 32'h1);
`endif
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("x0_rd0_valid", {31'h0, rd0_valid}, 32'h1);
`ifdef X0_HARDWIRE_EN
        chk("x0_rd0_data", rd0_data, 32'h0);
`else
        chk("x0_rd0_data", rd0_data, 32'h1234);
`endif

        // Reset lands after rd1 is granted, before the grant edge.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 3);
        #1;
        chk("rst_mid_gnt", {31'h0, rd1_gnt}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_hi");
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("rst_mid_after%0d", c), {30'h0, rd0_valid, rd1_valid}, 32'h0);
            @(negedge clk);
        end

        // Reset lands in the valid cycle: the pending read is dropped.
        drive(0, 0, 0, 0, 0, 1, 3);
        #1;
        chk("rst_vld_gnt", {31'h0, rd1_gnt}, 32'h1);
        @(posedge clk);
        #1;
        chk("rst_vld_pre", {31'h0, rd1_valid}, 32'h1);
        chk("rst_vld_data", rd1_data, 32'h7);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_vld_hi");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_vld_after", {30'h0, rd0_valid, rd1_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
